// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_stage_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic valid;
      logic pcsrc;
      logic regwrite;
      logic memwrite;
      logic memtoreg;
   } mem_ctrl_t;

   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus; the pipeline stage is master, the memory is slave.
interface mem_stage_if #(
   parameter int DATA_W = 32
) ();

   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter; timeout_hit flags the abandon threshold.
module mem_wait_timer
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic timeout_hit
);

   localparam int               CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] TC    = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != TC)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign timeout_hit = (count == TC);

endmodule

// File: rtl/memory_access_stage.sv
// EX/MEM register, data-memory handshake with timeout recovery, and MEM/WB register.
//
//   state | meaning
//   RUN   | M completes this cycle unless a memory op is left unacknowledged
//   WAIT  | memory op outstanding; wait counter running toward TIMEOUT
module memory_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_e,
   input  logic              flush_e,
   input  logic              pcsrc_m_in,
   input  logic              regwrite_m_in,
   input  logic              memwrite_m_in,
   input  logic              memtoreg_e,
   input  logic [DATA_W-1:0] alu_result_e,
   input  logic [DATA_W-1:0] write_data_e,
   input  logic [REG_W-1:0]  wa3_e,
   mem_stage_if.master       dmem,
   output logic              stall_m,
   output logic              valid_w,
   output logic              regwrite_w,
   output logic              pcsrc_w,
   output logic [REG_W-1:0]  wa3_w,
   output logic [DATA_W-1:0] result_w,
   output logic              mem_err
);

   mem_ctrl_t         e_ctrl;
   mem_ctrl_t         m_ctrl;
   logic [DATA_W-1:0] m_alu;
   logic [DATA_W-1:0] m_wdata;
   logic [REG_W-1:0]  m_wa3;

   state_t            state_q;
   state_t            state_d;
   logic              mem_op;
   logic              ack_ok;
   logic              timer_hit;
   logic              timeout_hit;
   logic              abandon;
   logic              timer_clr;
   logic              timer_en;

   always_comb begin
      e_ctrl = '0;
      if (valid_e && !flush_e) begin
         e_ctrl.valid    = 1'b1;
         e_ctrl.pcsrc    = pcsrc_m_in;
         e_ctrl.regwrite = regwrite_m_in;
         e_ctrl.memwrite = memwrite_m_in;
         e_ctrl.memtoreg = memtoreg_e;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ctrl  <= '0;
         m_alu   <= '0;
         m_wdata <= '0;
         m_wa3   <= '0;
      end else if (!stall_m) begin
         m_ctrl  <= e_ctrl;
         m_alu   <= alu_result_e;
         m_wdata <= write_data_e;
         m_wa3   <= wa3_e;
      end
   end

   // Both FSM states present the request, so it follows the M register directly.
   assign mem_op          = m_ctrl.valid & (m_ctrl.memwrite | m_ctrl.memtoreg);
   assign dmem.mem_req    = mem_op;
   assign dmem.mem_we     = m_ctrl.memwrite;
   assign dmem.mem_addr   = m_alu;
   assign dmem.mem_wdata  = m_wdata;

   assign ack_ok      = dmem.mem_req & dmem.mem_ack;
   assign timeout_hit = (state_q == WAIT) & timer_hit;
   assign stall_m     = dmem.mem_req & ~dmem.mem_ack & ~timeout_hit;
   // An ack arriving on the timeout cycle still completes the access.
   assign abandon     = timeout_hit & ~ack_ok;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .clr         (timer_clr),
      .en          (timer_en),
      .timeout_hit (timer_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_clr = 1'b0;
      timer_en  = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_op && !ack_ok) begin
               state_d  = WAIT;
               timer_en = 1'b1;
            end else begin
               timer_clr = 1'b1;
            end
         end
         WAIT: begin
            if (ack_ok || timeout_hit) begin
               state_d   = RUN;
               timer_clr = 1'b1;
            end else begin
               timer_en = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_w    <= 1'b0;
         regwrite_w <= 1'b0;
         pcsrc_w    <= 1'b0;
         wa3_w      <= '0;
         result_w   <= '0;
         mem_err    <= 1'b0;
      end else begin
         if (abandon) begin
            mem_err <= 1'b1;
         end
         if (stall_m) begin
            valid_w    <= 1'b0;
            regwrite_w <= 1'b0;
            pcsrc_w    <= 1'b0;
         end else begin
            valid_w    <= m_ctrl.valid;
            regwrite_w <= m_ctrl.regwrite & ~abandon;
            pcsrc_w    <= m_ctrl.pcsrc & ~abandon;
            wa3_w      <= m_wa3;
            result_w   <= m_ctrl.memtoreg ? dmem.mem_rdata : m_alu;
         end
      end
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench: directed scenarios plus a randomized instruction stream against a transaction model.
module tb_memory_access_stage;

   localparam int TIMEOUT = 15;

   typedef struct {
      logic        ld;
      logic        st;
      logic        rw;
      logic        pc;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] rdata;
      logic [3:0]  wa;
      int          d;
   } instr_t;

   logic        clk;
   logic        reset;
   logic        valid_e;
   logic        flush_e;
   logic        pcsrc_m_in;
   logic        regwrite_m_in;
   logic        memwrite_m_in;
   logic        memtoreg_e;
   logic [31:0] alu_result_e;
   logic [31:0] write_data_e;
   logic [3:0]  wa3_e;
   logic        stall_m;
   logic        valid_w;
   logic        regwrite_w;
   logic        pcsrc_w;
   logic [3:0]  wa3_w;
   logic [31:0] result_w;
   logic        mem_err;

   int checks;
   int errors;
   bit err_model;

   mem_stage_if #(.DATA_W(32)) dmem ();

   memory_access_stage #(
      .DATA_W  (32),
      .REG_W   (4),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .valid_e       (valid_e),
      .flush_e       (flush_e),
      .pcsrc_m_in    (pcsrc_m_in),
      .regwrite_m_in (regwrite_m_in),
      .memwrite_m_in (memwrite_m_in),
      .memtoreg_e    (memtoreg_e),
      .alu_result_e  (alu_result_e),
      .write_data_e  (write_data_e),
      .wa3_e         (wa3_e),
      .dmem          (dmem),
      .stall_m       (stall_m),
      .valid_w       (valid_w),
      .regwrite_w    (regwrite_w),
      .pcsrc_w       (pcsrc_w),
      .wa3_w         (wa3_w),
      .result_w      (result_w),
      .mem_err       (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive_e(input logic v, input logic f, input logic ld, input logic st,
                          input logic rw, input logic pc, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [3:0] wa);
      valid_e       = v;
      flush_e       = f;
      memtoreg_e    = ld;
      memwrite_m_in = st;
      regwrite_m_in = rw;
      pcsrc_m_in    = pc;
      alu_result_e  = alu;
      write_data_e  = wd;
      wa3_e         = wa;
   endtask

   // Invalid E slot with random control bits: M must still capture a clean bubble.
   task automatic drive_idle();
      drive_e(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
   endtask

   // One instruction through M; memory acks d cycles after the request first appears.
   task automatic run_instr(input string name, input logic ld, input logic st, input logic rw,
                            input logic pc, input logic [31:0] alu, input logic [31:0] wd,
                            input logic [3:0] wa, input int d, input logic [31:0] rdata);
      bit memop;
      bit abandon;
      int c;
      int stalls;
      memop   = ld | st;
      abandon = memop && (d > TIMEOUT);
      c       = memop ? ((d < TIMEOUT) ? d : TIMEOUT) : 0;
      stalls  = 0;
      @(negedge clk);
      drive_e(1'b1, 1'b0, ld, st, rw, pc, alu, wd, wa);
      @(negedge clk);
      drive_idle();
      for (int cyc = 0; cyc <= c; cyc++) begin
         if (cyc > 0) @(negedge clk);
         dmem.mem_ack   = memop ? (cyc == d) : 1'($urandom_range(0, 1));
         dmem.mem_rdata = (memop && cyc == d) ? rdata : $urandom;
         #1;
         checks++;
         if (dmem.mem_req !== memop)
            begin errors++; $display("FAIL %s mem_req cyc %0d: got %b expected %b", name, cyc, dmem.mem_req, memop); end
         if (memop) begin
            checks++;
            if ({dmem.mem_we, dmem.mem_addr, dmem.mem_wdata} !== {st, alu, wd})
               begin errors++; $display("FAIL %s req fields cyc %0d: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                        name, cyc, dmem.mem_we, dmem.mem_addr, dmem.mem_wdata, st, alu, wd); end
         end
         checks++;
         if (stall_m !== (cyc < c))
            begin errors++; $display("FAIL %s stall_m cyc %0d: got %b expected %b", name, cyc, stall_m, (cyc < c)); end
         if (cyc > 0) begin
            checks++;
            if ({valid_w, regwrite_w, pcsrc_w} !== 3'b000)
               begin errors++; $display("FAIL %s W bubble cyc %0d: got %b expected 000", name, cyc, {valid_w, regwrite_w, pcsrc_w}); end
         end
         if (stall_m === 1'b1) stalls++;
      end
      if (abandon) err_model = 1'b1;
      @(negedge clk);
      dmem.mem_ack = 1'b0;
      #1;
      checks++;
      if (stalls != c)
         begin errors++; $display("FAIL %s stall count: got %0d expected %0d", name, stalls, c); end
      checks++;
      if ({valid_w, regwrite_w, pcsrc_w, wa3_w} !== {1'b1, rw & ~abandon, pc & ~abandon, wa})
         begin errors++; $display("FAIL %s W ctrl: got v=%b rw=%b pc=%b wa=%0d expected v=1 rw=%b pc=%b wa=%0d",
                                  name, valid_w, regwrite_w, pcsrc_w, wa3_w, rw & ~abandon, pc & ~abandon, wa); end
      if (!abandon) begin
         checks++;
         if (result_w !== (ld ? rdata : alu))
            begin errors++; $display("FAIL %s result_w: got %h expected %h", name, result_w, (ld ? rdata : alu)); end
      end
      checks++;
      if (mem_err !== err_model)
         begin errors++; $display("FAIL %s mem_err: got %b expected %b", name, mem_err, err_model); end
      checks++;
      if (dmem.mem_req !== 1'b0)
         begin errors++; $display("FAIL %s mem_req after completion: got %b expected 0", name, dmem.mem_req); end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({dmem.mem_req, dmem.mem_we, dmem.mem_addr, dmem.mem_wdata, stall_m} !== '0)
         begin errors++; $display("FAIL reset mem side: got req=%b we=%b addr=%h wdata=%h stall=%b expected all 0",
                                  dmem.mem_req, dmem.mem_we, dmem.mem_addr, dmem.mem_wdata, stall_m); end
      checks++;
      if ({valid_w, regwrite_w, pcsrc_w, wa3_w, result_w, mem_err} !== '0)
         begin errors++; $display("FAIL reset W side: got v=%b rw=%b pc=%b wa=%0d res=%h err=%b expected all 0",
                                  valid_w, regwrite_w, pcsrc_w, wa3_w, result_w, mem_err); end
      @(negedge clk);
      reset = 1'b1;
      drive_idle();
   endtask

   task automatic test_alu();
      run_instr("alu_a5", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, $urandom, 4'd3, 0, 32'h0);
      run_instr("alu_pcsrc", 1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom, 4'd12, 0, 32'h0);
   endtask

   task automatic test_load_wait();
      run_instr("load_wait3", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, $urandom, 4'd9, 3, 32'hDEAD_BEEF);
   endtask

   task automatic test_store_zero_wait();
      run_instr("store_0wait", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_1234, 4'd2, 0, $urandom);
      run_instr("store_rw", 1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 4'd6, 2, $urandom);
   endtask

   task automatic test_ack_at_timeout();
      run_instr("ack_at_timeout", 1'b1, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 4'd4, TIMEOUT, 32'h0BAD_F00D);
   endtask

   task automatic test_timeout();
      run_instr("timeout_load", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, $urandom, 4'd5, 99, $urandom);
      run_instr("after_timeout", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0077, $urandom, 4'd1, 0, 32'h0);
   endtask

   task automatic test_flush();
      @(negedge clk);
      drive_e(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h1234, 4'd5);
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if ({dmem.mem_req, stall_m} !== 2'b00)
         begin errors++; $display("FAIL flush M bubble: got req=%b stall=%b expected 00", dmem.mem_req, stall_m); end
      @(negedge clk);
      #1;
      checks++;
      if ({valid_w, regwrite_w, pcsrc_w} !== 3'b000)
         begin errors++; $display("FAIL flush W bubble: got %b expected 000", {valid_w, regwrite_w, pcsrc_w}); end
      // load stalls, then a flushed store arrives in E while M is frozen
      drive_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'd7);
      dmem.mem_ack = 1'b0;
      @(negedge clk);
      drive_e(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h55, 4'd8);
      #1;
      checks++;
      if ({stall_m, dmem.mem_req, dmem.mem_addr} !== {2'b11, 32'h200})
         begin errors++; $display("FAIL flush-in-stall first cycle: got stall=%b req=%b addr=%h expected 1 1 200",
                                  stall_m, dmem.mem_req, dmem.mem_addr); end
      @(negedge clk);
      #1;
      checks++;
      if ({stall_m, dmem.mem_req, dmem.mem_we, dmem.mem_addr} !== {3'b110, 32'h200})
         begin errors++; $display("FAIL flush-in-stall M held: got stall=%b req=%b we=%b addr=%h expected 1 1 0 200",
                                  stall_m, dmem.mem_req, dmem.mem_we, dmem.mem_addr); end
      dmem.mem_ack   = 1'b1;
      dmem.mem_rdata = 32'h0000_CAFE;
      #1;
      checks++;
      if (stall_m !== 1'b0)
         begin errors++; $display("FAIL flush-in-stall ack release: got stall=%b expected 0", stall_m); end
      @(negedge clk);
      dmem.mem_ack = 1'b0;
      drive_idle();
      #1;
      checks++;
      if ({valid_w, regwrite_w, wa3_w, result_w, dmem.mem_req} !== {2'b11, 4'd7, 32'h0000_CAFE, 1'b0})
         begin errors++; $display("FAIL flush-in-stall retire: got v=%b rw=%b wa=%0d res=%h req=%b expected 1 1 7 0000cafe 0",
                                  valid_w, regwrite_w, wa3_w, result_w, dmem.mem_req); end
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      drive_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 4'd11);
      dmem.mem_ack = 1'b0;
      @(negedge clk);
      drive_idle();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({stall_m, dmem.mem_req} !== 2'b11)
         begin errors++; $display("FAIL reset_wait precondition: got stall=%b req=%b expected 11", stall_m, dmem.mem_req); end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({dmem.mem_req, stall_m, valid_w, regwrite_w, pcsrc_w, wa3_w, result_w, mem_err} !== '0)
         begin errors++; $display("FAIL reset_wait async clear: got req=%b stall=%b v=%b rw=%b pc=%b wa=%0d res=%h err=%b expected all 0",
                                  dmem.mem_req, stall_m, valid_w, regwrite_w, pcsrc_w, wa3_w, result_w, mem_err); end
      err_model = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_instr("post_reset_alu", 1'b0, 1'b0, 1'b1, 1'b0, 32'h1357_9BDF, $urandom, 4'd14, 0, 32'h0);
      run_instr("post_reset_load", 1'b1, 1'b0, 1'b1, 1'b0, 32'h84, $urandom, 4'd13, 1, 32'h2468_ACE0);
   endtask

   // Randomized stream: E holds while stalled; expected W order, results and stall total from the model.
   task automatic test_back_to_back(input int n);
      instr_t exp_q[$];
      instr_t mem_q[$];
      instr_t it;
      instr_t w;
      int     issued;
      int     wait_cnt;
      int     stalls;
      int     exp_stalls;
      int     budget;
      int     kind;
      bit     consumed;
      bit     v;
      bit     f;
      bit     ack;
      bit     aband;
      issued     = 0;
      wait_cnt   = 0;
      stalls     = 0;
      exp_stalls = 0;
      budget     = 0;
      consumed   = 1'b1;
      while (issued < n || !consumed || exp_q.size() > 0) begin
         if (budget >= 4000) begin
            errors++;
            $display("FAIL b2b drain: got %0d pending after %0d cycles expected 0", exp_q.size(), budget);
            break;
         end
         @(negedge clk);
         budget++;
         if (consumed) begin
            if (issued < n) begin
               kind     = $urandom_range(0, 2);
               it.ld    = (kind == 1);
               it.st    = (kind == 2);
               it.rw    = 1'($urandom_range(0, 1));
               it.pc    = 1'($urandom_range(0, 1));
               it.alu   = $urandom;
               it.wd    = $urandom;
               it.rdata = $urandom;
               it.wa    = 4'($urandom);
               it.d     = $urandom_range(0, TIMEOUT + 2);
               v        = ($urandom_range(0, 4) != 0);
               f        = ($urandom_range(0, 5) == 0);
               drive_e(v, f, it.ld, it.st, it.rw, it.pc, it.alu, it.wd, it.wa);
               if (v && !f) begin
                  exp_q.push_back(it);
                  if (it.ld || it.st) begin
                     mem_q.push_back(it);
                     exp_stalls += (it.d < TIMEOUT) ? it.d : TIMEOUT;
                  end
               end
               issued++;
            end else begin
               drive_idle();
            end
         end
         ack = 1'b0;
         dmem.mem_rdata = $urandom;
         if (mem_q.size() > 0 && dmem.mem_req === 1'b1) begin
            ack = (wait_cnt == mem_q[0].d);
            if (ack) dmem.mem_rdata = mem_q[0].rdata;
         end else if (dmem.mem_req !== 1'b1) begin
            ack = 1'($urandom_range(0, 1));
         end
         dmem.mem_ack = ack;
         #1;
         if (dmem.mem_req === 1'b1) begin
            checks++;
            if (mem_q.size() == 0)
               begin errors++; $display("FAIL b2b unexpected mem_req: got 1 expected 0"); end
            else if ({dmem.mem_we, dmem.mem_addr, dmem.mem_wdata} !== {mem_q[0].st, mem_q[0].alu, mem_q[0].wd})
               begin errors++; $display("FAIL b2b req fields: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                        dmem.mem_we, dmem.mem_addr, dmem.mem_wdata, mem_q[0].st, mem_q[0].alu, mem_q[0].wd); end
         end
         if (valid_w === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b unexpected retire: got valid_w=1 expected 0");
            end else begin
               w     = exp_q.pop_front();
               aband = (w.ld || w.st) && (w.d > TIMEOUT);
               if (aband) err_model = 1'b1;
               if ({regwrite_w, pcsrc_w, wa3_w} !== {w.rw & ~aband, w.pc & ~aband, w.wa})
                  begin errors++; $display("FAIL b2b W ctrl: got rw=%b pc=%b wa=%0d expected rw=%b pc=%b wa=%0d",
                                           regwrite_w, pcsrc_w, wa3_w, w.rw & ~aband, w.pc & ~aband, w.wa); end
               if (!aband) begin
                  checks++;
                  if (result_w !== (w.ld ? w.rdata : w.alu))
                     begin errors++; $display("FAIL b2b result_w: got %h expected %h", result_w, (w.ld ? w.rdata : w.alu)); end
               end
            end
         end
         checks++;
         if (mem_err !== err_model)
            begin errors++; $display("FAIL b2b mem_err: got %b expected %b", mem_err, err_model); end
         if (stall_m === 1'b1) stalls++;
         consumed = (stall_m !== 1'b1);
         if (dmem.mem_req === 1'b1 && mem_q.size() > 0) begin
            if (ack || wait_cnt == TIMEOUT) begin
               wait_cnt = 0;
               void'(mem_q.pop_front());
            end else begin
               wait_cnt++;
            end
         end
      end
      checks++;
      if (stalls != exp_stalls)
         begin errors++; $display("FAIL b2b stall total: got %0d expected %0d", stalls, exp_stalls); end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      err_model      = 1'b0;
      reset          = 1'b0;
      dmem.mem_ack   = 1'b0;
      dmem.mem_rdata = '0;
      drive_e(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
      repeat (3) @(negedge clk);
      test_reset();
      test_alu();
      test_load_wait();
      test_store_zero_wait();
      test_ack_at_timeout();
      test_timeout();
      test_flush();
      test_reset_in_wait();
      test_back_to_back(80);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage directly downstream of the execute-stage condition logic.
- Holds the EX/MEM pipeline register and consumes the condition-qualified PCSrcM, RegWriteM and MemWriteM, plus the ALU result.
- Drives a req/ack data-memory handshake and produces registered MEM/WB outputs.
- Generates the memory stall for the hazard unit and recovers from unresponsive memory with a timeout.

Parameters:
DATA_W, 32, data/address width
REG_W, 4, register-file address width
TIMEOUT, 15, max wait cycles for mem_ack before the access is abandoned

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
valid_e  in  1  execute stage presents a real instruction
flush_e  in  1  squash the instruction entering M (branch taken)
pcsrc_m_in  in  1  condition-qualified PC write
regwrite_m_in  in  1  condition-qualified register write
memwrite_m_in  in  1  condition-qualified store
memtoreg_e  in  1  instruction is a load
alu_result_e  in  DATA_W  ALU result / memory address
write_data_e  in  DATA_W  store data
wa3_e  in  REG_W  destination register
mem_req  out  1  memory request
mem_we  out  1  request is a store
mem_addr  out  DATA_W  request address
mem_wdata  out  DATA_W  store data
mem_ack  in  1  memory completes the request this cycle
mem_rdata  in  DATA_W  load data, valid with mem_ack
stall_m  out  1  freeze F/D/E and the M register
valid_w  out  1  W holds a real instruction
regwrite_w  out  1  register write enable to writeback
pcsrc_w  out  1  PC write to writeback
wa3_w  out  REG_W  destination register
result_w  out  DATA_W  load data or ALU result
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: all M and W registers are 0, including mem_err and the wait counter. FSM is in RUN. All outputs are 0.
- Reset asserted mid-WAIT aborts the access immediately: mem_req drops asynchronously.
- M capture, each edge with stall_m=0:
  - M valid <= valid_e & ~flush_e.
  - Control, data and wa3 are captured from the E inputs.
  - A flushed or invalid capture zeroes all control bits.
- Memory op: M valid & (memwrite | memtoreg).
  - mem_req = memory op & state ∈ {RUN, WAIT}.
  - mem_we = M memwrite.
  - mem_addr and mem_wdata come from the M register.
  - All request fields stay stable while mem_req is high.
- stall_m = mem_req & ~mem_ack & ~timeout_hit (combinational).
  - With zero-wait memory (ack in the same cycle) there is no stall.
  - ALU ops have a fixed 1-cycle M latency.
- FSM RUN:
  - Memory op with no ack → WAIT; the counter starts at 1.
  - Otherwise M completes this cycle and the state stays RUN.
- FSM WAIT:
  - The counter increments each cycle.
  - On mem_ack: complete and return to RUN.
  - Counter == TIMEOUT without ack (timeout_hit): abandon the access. mem_req deasserts next cycle; mem_err <= 1 (sticky until reset); the instruction retires with regwrite_w=0 and pcsrc_w=0; return to RUN.
  - The counter saturates; it never wraps.
- Completion transfer to W (registered):
  - valid_w <= M valid.
  - result_w <= load ? mem_rdata : alu_result.
  - regwrite_w, pcsrc_w and wa3_w come from M.
- In cycles with stall_m=1, W receives a bubble: valid_w=0, regwrite_w=0, pcsrc_w=0.
- A store writes no register unless the instruction carries regwrite.
- mem_ack while mem_req=0 is ignored.
- flush_e while stall_m=1 is ignored: M is held, and E stays frozen upstream.
- mem_ack together with timeout_hit: the ack wins, and the load completes normally.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum {RUN, WAIT};
  - typedef mem_ctrl_t {valid, pcsrc, regwrite, memwrite, memtoreg};
  - the counter width function $clog2(TIMEOUT+1).
- Sub-module mem_wait_timer: saturating counter with clear/enable inputs and a timeout_hit output.

Test Plan:
- ALU op, regwrite=1, alu_result=0x0000_00A5, wa3=3 → one cycle later valid_w=1, regwrite_w=1, wa3_w=3, result_w=0xA5; mem_req never high.
- Load at 0x100 with mem_ack after 3 wait cycles, rdata=0xDEAD_BEEF → stall_m high exactly 3 cycles, then result_w=0xDEADBEEF and regwrite_w=1; W bubbles during the stall.
- Store of 0x1234 to 0x40 with same-cycle ack → mem_we=1, mem_wdata=0x1234; no stall; valid_w=1, regwrite_w=0.
- Load with no ack, TIMEOUT=15 → stall for 15 cycles, then mem_err=1 and the instruction retires with regwrite_w=0; next ALU op flows normally and mem_err stays 1.
- flush_e=1 with a valid store in E → M bubble, mem_req stays 0, valid_w=0. A second flush arriving during an existing stall → M contents unchanged.
- reset driven low during WAIT → mem_req, stall_m and all W outputs become 0 immediately; after release, state is RUN.
